// File: rtl/data_memory_ctrl.sv
//------------------------------------------------------------------------------
// Module      : data_memory_ctrl
// Description : Big-endian byte-addressable data memory with byte/half/word
//               access, sign/zero extension and configurable wait states
//               behind a valid/ready request handshake. Optional misalignment
//               faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [1:0]                     req_size,
  input  logic                           req_unsigned,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [31:0]                    req_wdata,
  output logic                           resp_valid,
  output logic [31:0]                    resp_rdata,
  output logic                           resp_err,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_word
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              w_accept;
  logic              w_done;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oob;
  logic              w_misalign;
  logic              w_fault;
  logic [1:0]        w_off;
  logic [31:0]       w_cur;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_wword;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    w_accept  = req_valid && (state_q == S_IDLE);
    w_done    = (state_q == S_BUSY) && (cnt_q == 4'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept) begin
      cnt_d = WAIT_LD;
    end else if ((state_q == S_BUSY) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------- decode
  assign w_idx = addr_q[IDX_W+1:2];

  // Storage depth is a power of two, so any set bit above the index is out of range
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign w_oob = |addr_q[ADDR_W-1:IDX_W+2];
    end else begin : g_norange
      assign w_oob = 1'b0;
    end
  endgenerate

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_misalign = ((size_q == SZ_H) && addr_q[0]) ||
                 ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
    w_off      = addr_q[1:0];
  end
`else
  always_comb begin
    w_misalign = 1'b0;
    case (size_q)
      SZ_H:    w_off = {addr_q[1], 1'b0};
      SZ_W:    w_off = 2'b00;
      default: w_off = addr_q[1:0];
    endcase
  end
`endif

  assign w_fault = w_oob || (size_q == 2'b11) || w_misalign;
  assign w_cur   = mem_q[w_idx];

  // ---------------------------------------------------------------- lanes
  always_comb begin
    case (w_off)
      2'd0:    w_byte = w_cur[31:24];
      2'd1:    w_byte = w_cur[23:16];
      2'd2:    w_byte = w_cur[15:8];
      default: w_byte = w_cur[7:0];
    endcase
    w_half = w_off[1] ? w_cur[15:0] : w_cur[31:16];

    case (size_q)
      SZ_B:    w_load = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    w_load = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      SZ_W:    w_load = w_cur;
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_wword = w_cur;
    case (size_q)
      SZ_B: begin
        case (w_off)
          2'd0:    w_wword[31:24] = wdata_q[7:0];
          2'd1:    w_wword[23:16] = wdata_q[7:0];
          2'd2:    w_wword[15:8]  = wdata_q[7:0];
          default: w_wword[7:0]   = wdata_q[7:0];
        endcase
      end
      SZ_H: begin
        if (w_off[1]) w_wword[15:0]  = wdata_q[15:0];
        else          w_wword[31:16] = wdata_q[15:0];
      end
      SZ_W:    w_wword = wdata_q;
      default: w_wword = w_cur;
    endcase
  end

  assign resp_rdata_d = (w_fault || we_q) ? 32'd0 : w_load;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= w_done;
      if (w_done) begin
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= w_fault;
      end
      if (w_accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is never reset; an access interrupted by reset must not commit
  always_ff @(posedge clk) begin
    if (rst_n && w_done && we_q && !w_fault) begin
      mem_q[w_idx] <= w_wword;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_word   = mem_q[dbg_addr];

endmodule

`default_nettype wire
